pcm_buf_reader: RTL and testbench

//  Drain side of the 512-sample PCM buffer RAM loaded by the ROM-to-buffer writer.
//  On START_I, reads NUM_SAMPLE consecutive words from the buffer RAM's read port
//  (1-cycle read latency) and presents them as a valid/ready sample stream to the output stage.

---
 rtl/pcm_buf_reader_pkg.sv | 15 +
 rtl/pcm_buf_reader_if.sv | 26 ++
 rtl/pcm_buf_reader_skid_fifo.sv | 49 ++++
 rtl/pcm_buf_reader.sv | 135 +++++++++++++
 tb/tb_pcm_buf_reader.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pcm_buf_reader_pkg.sv
// Shared constants and FSM encoding for the PCM buffer reader slice.
package pcm_buf_reader_pkg;

    localparam int ADDRESS_WIDTH  = 9;
    localparam int DATA_WIDTH     = 32;
    localparam int NUM_SAMPLE_DEF = 512;
    localparam int CNT_W          = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pcm_buf_reader_if.sv
// Buffer RAM read port plus the valid/ready sample stream of the PCM buffer reader.
interface pcm_buf_reader_if
    import pcm_buf_reader_pkg::*;
#(
    parameter int ADDR_W = ADDRESS_WIDTH,
    parameter int DATA_W = DATA_WIDTH
) ();

    logic [ADDR_W-1:0] MEM_ADDRESS_O;
    logic              MEM_EN_O;
    logic [DATA_W-1:0] MEM_DATA_I;
    logic [DATA_W-1:0] SAMPLE_O;
    logic              VALID_O;
    logic              READY_I;

    modport master (
        output MEM_ADDRESS_O, MEM_EN_O, SAMPLE_O, VALID_O,
        input  MEM_DATA_I, READY_I
    );

    modport slave (
        input  MEM_ADDRESS_O, MEM_EN_O, SAMPLE_O, VALID_O,
        output MEM_DATA_I, READY_I
    );

endinterface

// File: rtl/pcm_buf_reader_skid_fifo.sv
// Two-entry skid FIFO between the buffer RAM read port and the sample stream.
module pcm_skid_fifo
#(
    parameter int DATA_W = 32
) (
    input  logic              CLOCK_I,
    input  logic              RESET_I,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge CLOCK_I) begin
        if (RESET_I) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pcm_buf_reader.sv
// Drains one frame from the PCM buffer RAM into a valid/ready sample stream.
// Optional PCM_CHECKSUM_EN adds CHECKSUM_O, a running sum of the transferred samples.
module pcm_buf_reader
    import pcm_buf_reader_pkg::*;
#(
    parameter int NUM_SAMPLE = NUM_SAMPLE_DEF,
    parameter int ADDR_W     = ADDRESS_WIDTH,
    parameter int DATA_W     = DATA_WIDTH
) (
    input  logic              CLOCK_I,
    input  logic              RESET_I,
    input  logic              START_I,
    input  logic [ADDR_W-1:0] START_ADDR_I,
    pcm_buf_reader_if.master  bus,
    output logic              DONE_O
`ifdef PCM_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] CHECKSUM_O
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLE - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  accept_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              inflight;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_valid;
    logic              xfer;
    logic              start_acc;
    logic              issue;
    logic [2:0]        credit_used;

    assign fifo_valid        = (fifo_count != 2'd0);
    assign xfer              = fifo_valid && bus.READY_I;
    assign bus.MEM_EN_O      = inflight;
    assign bus.MEM_ADDRESS_O = mem_addr;
    assign bus.SAMPLE_O      = fifo_head;
    assign bus.VALID_O       = fifo_valid;
    assign DONE_O            = (state == S_IDLE);

    always_ff @(posedge CLOCK_I) begin
        if (RESET_I) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The slot freed by a transfer on this edge counts as credit, so a held READY_I gives one sample per cycle.
    always_comb begin
        state_nxt   = state;
        start_acc   = 1'b0;
        issue       = 1'b0;
        credit_used = 3'(fifo_count) + 3'(inflight) - 3'(xfer);
        case (state)
            S_IDLE: begin
                if (START_I) begin
                    start_acc = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (credit_used < 3'd2) begin
                    issue = 1'b1;
                    if (issue_cnt == LAST_CNT) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (xfer && (accept_cnt == LAST_CNT)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_I) begin
        if (RESET_I) begin
            issue_cnt  <= '0;
            accept_cnt <= '0;
            rd_addr    <= '0;
            mem_addr   <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= issue;
            if (start_acc) begin
                rd_addr    <= START_ADDR_I;
                issue_cnt  <= '0;
                accept_cnt <= '0;
            end
            if (issue) begin
                mem_addr  <= rd_addr;
                rd_addr   <= rd_addr + 1'b1;
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (xfer) begin
                accept_cnt <= accept_cnt + 1'b1;
            end
        end
    end

`ifdef PCM_CHECKSUM_EN
    always_ff @(posedge CLOCK_I) begin
        if (RESET_I) begin
            CHECKSUM_O <= '0;
        end else if (start_acc) begin
            CHECKSUM_O <= '0;
        end else if (xfer) begin
            CHECKSUM_O <= CHECKSUM_O + fifo_head;
        end
    end
`else
`endif

    pcm_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .CLOCK_I   (CLOCK_I),
        .RESET_I   (RESET_I),
        .push      (inflight),
        .push_data (bus.MEM_DATA_I),
        .pop       (xfer),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_pcm_buf_reader.sv
// Directed bench for pcm_buf_reader: RAM model returns data = address, scoreboard queues hold expected reads/samples.
module tb_pcm_buf_reader;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int NS = 512;

    logic          CLOCK_I = 1'b0;
    logic          RESET_I;
    logic          START_I;
    logic [AW-1:0] START_ADDR_I;
    logic          DONE_O;
`ifdef PCM_CHECKSUM_EN
    logic [DW-1:0] CHECKSUM_O;
`endif

    pcm_buf_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    pcm_buf_reader #(
        .NUM_SAMPLE (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .CLOCK_I      (CLOCK_I),
        .RESET_I      (RESET_I),
        .START_I      (START_I),
        .START_ADDR_I (START_ADDR_I),
        .bus          (bus),
        .DONE_O       (DONE_O)
`ifdef PCM_CHECKSUM_EN
        ,
        .CHECKSUM_O   (CHECKSUM_O)
`endif
    );

    always #5 CLOCK_I = ~CLOCK_I;

    // Data only meaningful while a read is in flight; anything else shows up as a bad sample.
    assign bus.MEM_DATA_I = bus.MEM_EN_O ? DW'(bus.MEM_ADDRESS_O) : 32'hDEAD_BEEF;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            n_issued;
    int            n_accepted;
    bit            prev_valid;
    bit            prev_xfer;
    logic [DW-1:0] prev_sample;
    logic [DW-1:0] sum_model;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit rdy, input bit st);
        logic [DW-1:0] e;
        logic [AW-1:0] ea;
        @(negedge CLOCK_I);
        bus.READY_I = rdy;
        START_I     = st;
        if (prev_valid && !prev_xfer) begin
            chk("hold_valid", 32'(bus.VALID_O), 1);
            chk("hold_sample", bus.SAMPLE_O, prev_sample);
        end
        if (bus.MEM_EN_O) begin
            n_issued++;
            chk("read_expected", 32'(addr_q.size() != 0), 1);
            if (addr_q.size() != 0) begin
                ea = addr_q.pop_front();
                chk("read_addr", 32'(bus.MEM_ADDRESS_O), 32'(ea));
            end
        end
        chk("outstanding_le2", 32'((n_issued - n_accepted) <= 2), 1);
        if (bus.VALID_O && rdy) begin
            chk("sample_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sample", bus.SAMPLE_O, e);
                sum_model = sum_model + e;
            end
            n_accepted++;
        end
        prev_valid  = bus.VALID_O;
        prev_xfer   = bus.VALID_O && rdy;
        prev_sample = bus.SAMPLE_O;
    endtask

    task automatic do_reset(input int n);
        @(negedge CLOCK_I);
        RESET_I     = 1'b1;
        START_I     = 1'b0;
        bus.READY_I = 1'b0;
        repeat (n) @(negedge CLOCK_I);
        chk("rst_done", 32'(DONE_O), 1);
        chk("rst_valid", 32'(bus.VALID_O), 0);
        chk("rst_mem_en", 32'(bus.MEM_EN_O), 0);
        chk("rst_addr", 32'(bus.MEM_ADDRESS_O), 0);
        chk("rst_sample", bus.SAMPLE_O, 0);
`ifdef PCM_CHECKSUM_EN
        chk("rst_checksum", CHECKSUM_O, 0);
`endif
        RESET_I = 1'b0;
        exp_q.delete();
        addr_q.delete();
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
        n_issued   = 0;
        n_accepted = 0;
        sum_model  = '0;
    endtask

    // mode 0: READY held; 1: random READY; 2: 20-cycle stall with START pulse; 3: as 0 plus START when DONE rises
    task automatic run_frame(input logic [AW-1:0] a, input int mode, input int abort_at);
        int            first_v;
        int            done_t;
        bit            r;
        bit            st;
        logic [AW-1:0] ad;
        START_ADDR_I = a;
        for (int i = 0; i < NS; i++) begin
            ad = a + AW'(i);
            addr_q.push_back(ad);
            exp_q.push_back(DW'(ad));
        end
        n_issued   = 0;
        n_accepted = 0;
        sum_model  = '0;
        first_v    = -1;
        done_t     = -1;
        tick(1'b1, 1'b1);
        chk("done_before_start", 32'(DONE_O), 1);
        for (int k = 1; k < 4000; k++) begin
            case (mode)
                1:       r = 1'($urandom_range(0, 1));
                2:       r = !(k >= 100 && k < 120);
                default: r = 1'b1;
            endcase
            st = (mode == 2 && k == 110) || (mode == 3 && k == 514);
            tick(r, st);
            if (k == 1) chk("done_low_after_start", 32'(DONE_O), 0);
            if (mode == 2 && k == 119) chk("stall_outstanding", 32'(n_issued - n_accepted), 2);
            if (first_v < 0 && bus.VALID_O) first_v = k;
            if (abort_at > 0 && k == abort_at) break;
            if (k > 1 && DONE_O) begin
                done_t = k;
                break;
            end
        end
        if (abort_at > 0) begin
            do_reset(1);
        end else begin
            chk("frame_done_in_bound", 32'(done_t > 0), 1);
            if (mode == 0 || mode == 3) begin
                chk("first_valid_latency", 32'(first_v), 3);
                chk("frame_cycles", 32'(done_t), 515);
            end
            chk("samples_left", 32'(exp_q.size()), 0);
            chk("reads_left", 32'(addr_q.size()), 0);
            chk("accepted", 32'(n_accepted), NS);
            chk("valid_after_done", 32'(bus.VALID_O), 0);
`ifdef PCM_CHECKSUM_EN
            chk("checksum", CHECKSUM_O, sum_model);
`endif
            for (int j = 0; j < 3; j++) begin
                tick(1'b1, 1'b0);
                chk("idle_done", 32'(DONE_O), 1);
                chk("idle_mem_en", 32'(bus.MEM_EN_O), 0);
            end
`ifdef PCM_CHECKSUM_EN
            chk("checksum_stable", CHECKSUM_O, sum_model);
`endif
        end
    endtask

    initial begin
        RESET_I      = 1'b1;
        START_I      = 1'b0;
        START_ADDR_I = '0;
        bus.READY_I  = 1'b0;
        prev_valid   = 1'b0;
        prev_xfer    = 1'b0;
        n_issued     = 0;
        n_accepted   = 0;
        sum_model    = '0;

        do_reset(3);
        for (int j = 0; j < 5; j++) begin
            tick(1'b0, 1'b0);
            chk("idle_done", 32'(DONE_O), 1);
            chk("idle_valid", 32'(bus.VALID_O), 0);
            chk("idle_mem_en", 32'(bus.MEM_EN_O), 0);
        end

        run_frame(9'h000, 0, 0);
`ifdef PCM_CHECKSUM_EN
        chk("checksum_0_511", CHECKSUM_O, 32'd130816);
`endif
        run_frame(9'h000, 1, 0);
        run_frame(9'h1F0, 3, 0);
        run_frame(9'h055, 2, 0);
        run_frame(9'h0A0, 1, 60);
        run_frame(9'h1FF, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
